os_result_collector: RTL and testbench

// - Sits downstream of the OS matmul workflow FSM; samples its bottom-row result beats and rebuilds the full ROWS x COLS output matrix.
// - OS results leave the array bottom row first (row ROWS-1, then ROWS-2, ..., row 0). The block reorders them into row-major form.
// - Presents the assembled matrix to the consumer (BIST comparator / host) with a valid/ready handshake and flags protocol errors.

---
 rtl/os_result_collector.sv | 185 ++++++++++++++++++
 tb/tb_os_result_collector.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/os_result_collector.sv
// os_result_collector: rebuilds the ROWS x COLS OS result matrix from bottom-row-first beats.
// Define OS_COLLECT_CHECKSUM_EN to add the checksum port (running sum of captured words).
`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif

module os_result_collector #(
  parameter int WORD_SIZE  = 16,
  parameter int SKIP_BEATS = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [`COLS*WORD_SIZE-1:0]         matmul_output,
  input  logic [`COLS-1:0]                   output_col_valid,
  output logic [`ROWS*`COLS*WORD_SIZE-1:0]   result_matrix,
  output logic                               result_valid,
  input  logic                               result_ready,
  output logic                               busy,
  output logic                               protocol_err,
  output logic                               overrun_err
`ifdef OS_COLLECT_CHECKSUM_EN
  ,
  output logic [WORD_SIZE+$clog2(`ROWS*`COLS)-1:0] checksum
`endif
);
  localparam int ROWS  = `ROWS;
  localparam int COLS  = `COLS;
  localparam int ROW_W = COLS * WORD_SIZE;
  localparam int RC_W  = $clog2(ROWS) + 1;
  localparam int RI_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [1:0]      SKIP_N   = 2'(SKIP_BEATS);
  localparam logic [RC_W-1:0] LAST_ROW = RC_W'(ROWS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SKIP    = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  logic [2:0]      state_reg, state_next;
  logic [RC_W-1:0] row_cnt_reg, row_cnt_next, wr_idx;
  logic [1:0]      skip_cnt_reg, skip_cnt_next;
  logic            valid_reg, protocol_err_reg, overrun_err_reg;
  logic            beat, partial, take, load_result, proto_set, overrun_set;
  logic [RI_W-1:0] wr_row;
  logic [ROW_W-1:0] cap_mem [ROWS];
  logic [ROW_W-1:0] result_rows_reg [ROWS];

  assign beat    = &output_col_valid;
  assign partial = (|output_col_valid) && !beat;
  // The first data beat may be taken from IDLE or SKIP, where the row index is implicitly 0.
  assign wr_idx  = (state_reg == S_CAPTURE) ? row_cnt_reg : '0;
  assign wr_row  = RI_W'(LAST_ROW - wr_idx);

  always_comb begin
    state_next    = state_reg;
    row_cnt_next  = row_cnt_reg;
    skip_cnt_next = skip_cnt_reg;
    take          = 1'b0;
    load_result   = 1'b0;
    proto_set     = partial;
    overrun_set   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (beat) begin
          if (SKIP_BEATS == 0) begin
            take = 1'b1;
          end else begin
            state_next    = S_SKIP;
            skip_cnt_next = 2'd1;
          end
        end
      end
      S_SKIP: begin
        if (!beat) begin
          state_next    = S_IDLE;
          skip_cnt_next = '0;
        end else if (skip_cnt_reg == SKIP_N) begin
          take = 1'b1;
        end else begin
          skip_cnt_next = skip_cnt_reg + 2'd1;
        end
      end
      S_CAPTURE: begin
        if (beat) begin
          take = 1'b1;
        end else begin
          state_next   = S_IDLE;
          row_cnt_next = '0;
          proto_set    = 1'b1;
        end
      end
      S_DRAIN: begin
        if (output_col_valid == '0) begin
          state_next  = S_HOLD;
          load_result = 1'b1;
        end
      end
      S_HOLD: begin
        overrun_set = beat;
        if (result_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (take) begin
      skip_cnt_next = '0;
      if (wr_idx == LAST_ROW) begin
        state_next   = S_DRAIN;
        row_cnt_next = '0;
      end else begin
        state_next   = S_CAPTURE;
        row_cnt_next = wr_idx + RC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      row_cnt_reg      <= '0;
      skip_cnt_reg     <= '0;
      valid_reg        <= 1'b0;
      protocol_err_reg <= 1'b0;
      overrun_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      row_cnt_reg  <= row_cnt_next;
      skip_cnt_reg <= skip_cnt_next;
      if (load_result)
        valid_reg <= 1'b1;
      else if (state_reg == S_HOLD && result_ready)
        valid_reg <= 1'b0;
      if (proto_set)   protocol_err_reg <= 1'b1;
      if (overrun_set) overrun_err_reg  <= 1'b1;
    end
  end

  // Beats land in a capture buffer; the visible matrix only changes once a burst completes.
  always_ff @(posedge clk) begin
    if (take) cap_mem[wr_row] <= matmul_output;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROWS; i++) result_rows_reg[i] <= '0;
    end else if (load_result) begin
      for (int i = 0; i < ROWS; i++) result_rows_reg[i] <= cap_mem[i];
    end
  end

  generate
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_rows
      assign result_matrix[gi*ROW_W +: ROW_W] = result_rows_reg[gi];
    end
  endgenerate

`ifdef OS_COLLECT_CHECKSUM_EN
  localparam int CS_W = WORD_SIZE + $clog2(ROWS*COLS);
  logic [CS_W-1:0] beat_sum, checksum_reg;

  always_comb begin
    beat_sum = '0;
    for (int c = 0; c < COLS; c++)
      beat_sum = beat_sum + CS_W'(matmul_output[c*WORD_SIZE +: WORD_SIZE]);
  end

  always_ff @(posedge clk) begin
    if (rst)
      checksum_reg <= '0;
    else if (take)
      checksum_reg <= (wr_idx == '0) ? beat_sum : checksum_reg + beat_sum;
  end

  assign checksum = checksum_reg;
`endif

  assign result_valid = valid_reg;
  assign busy         = (state_reg == S_SKIP) || (state_reg == S_CAPTURE) || (state_reg == S_DRAIN);
  assign protocol_err = protocol_err_reg;
  assign overrun_err  = overrun_err_reg;

endmodule

// File: tb/tb_os_result_collector.sv
// Scoreboard bench for os_result_collector (ROWS=COLS=4, WORD_SIZE=16, SKIP_BEATS=1).
// The reference model maps element (r,c) to its bit slot and sends rows bottom-first.
`timescale 1ns/1ps
`ifndef ROWS
`define ROWS 4
`endif
`ifndef COLS
`define COLS 4
`endif

module tb_os_result_collector;
  localparam int R = 4;
  localparam int C = 4;
  localparam int W = 16;
  localparam int MW = R*C*W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [C*W-1:0] matmul_output = '0;
  logic [C-1:0]   output_col_valid = '0;
  logic [MW-1:0]  result_matrix;
  logic           result_valid;
  logic           result_ready = 1'b0;
  logic           busy, protocol_err, overrun_err;
`ifdef OS_COLLECT_CHECKSUM_EN
  logic [W+$clog2(R*C)-1:0] checksum;
`endif

  int checks = 0;
  int failures = 0;
  logic [15:0]   elem [R][C];
  logic [MW-1:0] exp_q [$];
  logic [31:0]   sum_q [$];
  logic [MW-1:0] held = '0;
  logic [MW-1:0] saved = '0;
  logic          prev_valid = 1'b0;

  always #5 clk = ~clk;

  os_result_collector #(.WORD_SIZE(W), .SKIP_BEATS(1)) dut (
    .clk(clk),
    .rst(rst),
    .matmul_output(matmul_output),
    .output_col_valid(output_col_valid),
    .result_matrix(result_matrix),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .busy(busy),
    .protocol_err(protocol_err),
    .overrun_err(overrun_err)
`ifdef OS_COLLECT_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Monitor: pops the scoreboard when a matrix is presented, then checks it stays put.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (result_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%0h required=no_result", result_matrix);
        end else begin
          logic [MW-1:0] e;
          logic [31:0] s;
          e = exp_q.pop_front();
          s = sum_q.pop_front();
          check("matrix", result_matrix, e);
`ifdef OS_COLLECT_CHECKSUM_EN
          check("checksum", MW'(checksum), MW'(s));
`endif
          held = e;
        end
      end else if (result_valid) begin
        check("hold_stable", result_matrix, held);
      end
      prev_valid = result_valid;
    end
  end

  function automatic logic [MW-1:0] model_matrix();
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        m[((r*C + c) + 1)*W - 1 -: W] = elem[r][c];
    return m;
  endfunction

  task automatic push_expected();
    logic [31:0] s;
    s = 0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        s += 32'(elem[r][c]);
    exp_q.push_back(model_matrix());
    sum_q.push_back(s);
  endtask

  task automatic drive(input logic [C*W-1:0] d, input logic [C-1:0] m);
    @(negedge clk);
    matmul_output    = d;
    output_col_valid = m;
  endtask

  task automatic junk_beat();
    drive({$urandom, $urandom}, '1);
  endtask

  // Data beat k carries row R-1-k.
  task automatic send_data(input int k0, input int k1);
    logic [C*W-1:0] b;
    for (int k = k0; k <= k1; k++) begin
      for (int c = 0; c < C; c++) b[c*W +: W] = elem[R-1-k][c];
      drive(b, '1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive({$urandom, $urandom}, '0);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!result_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!result_valid) begin
      failures++;
      $display("FAIL wait_valid actual=timeout required=result_valid within %0d cycles", budget);
    end
  endtask

  task automatic accept(input int delay);
    repeat (delay) @(negedge clk);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("valid_cleared", MW'(result_valid), '0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    output_col_valid = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic random_elems();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        elem[r][c] = 16'($urandom);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", MW'(result_valid), '0);
    check("rst_busy", MW'(busy), '0);
    check("rst_protocol_err", MW'(protocol_err), '0);
    check("rst_overrun_err", MW'(overrun_err), '0);
    check("rst_matrix", result_matrix, '0);
    rst = 1'b0;
    idle(2);

    // Nominal burst: junk beat then rows 3..0, element (r,c) = 16*r+c.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        elem[r][c] = 16'(16*r + c);
    saved = model_matrix();
    push_expected();
    junk_beat();
    send_data(0, 0);
    check("busy_in_burst", MW'(busy), MW'(1));
    send_data(1, 3);
    idle(1);
    check("latency_not_yet", MW'(result_valid), '0);
    @(negedge clk);
    check("latency_valid", MW'(result_valid), MW'(1));
    check("busy_in_hold", MW'(busy), '0);
    accept(2);
    check("matrix_after_ack", result_matrix, saved);

    // Randomized clean bursts with random consumer delay.
    for (int t = 0; t < 6; t++) begin
      random_elems();
      push_expected();
      junk_beat();
      send_data(0, R-1);
      idle(1);
      wait_valid(10);
      accept(int'($urandom_range(0, 3)));
      idle(int'($urandom_range(0, 2)));
    end
    check("no_errors_clean", MW'({protocol_err, overrun_err}), '0);

    // Backpressure: a whole second burst arrives while the first matrix is held.
    random_elems();
    saved = model_matrix();
    push_expected();
    junk_beat();
    send_data(0, R-1);
    idle(1);
    wait_valid(10);
    random_elems();
    junk_beat();
    send_data(0, R-1);
    idle(4);
    check("overrun_set", MW'(overrun_err), MW'(1));
    check("held_matrix", result_matrix, saved);
    check("still_valid", MW'(result_valid), MW'(1));
    accept(0);
    idle(3);

    // Gap: skip + 2 data beats, then the mask drops.
    pulse_reset();
    random_elems();
    junk_beat();
    send_data(0, 1);
    idle(1);
    @(negedge clk);
    check("gap_protocol_err", MW'(protocol_err), MW'(1));
    check("gap_idle", MW'(busy), '0);
    idle(4);
    check("gap_no_valid", MW'(result_valid), '0);

    // Partial mask during capture aborts; the next clean burst still completes.
    pulse_reset();
    random_elems();
    junk_beat();
    send_data(0, 1);
    drive({$urandom, $urandom}, 4'b0101);
    idle(1);
    check("partial_protocol_err", MW'(protocol_err), MW'(1));
    check("partial_idle", MW'(busy), '0);
    idle(3);
    random_elems();
    saved = model_matrix();
    push_expected();
    junk_beat();
    send_data(0, R-1);
    idle(1);
    wait_valid(10);
    accept(1);
    check("after_partial_matrix", result_matrix, saved);

    // Reset in the middle of a burst.
    random_elems();
    junk_beat();
    send_data(0, 1);
    @(negedge clk);
    rst = 1'b1;
    output_col_valid = '0;
    @(negedge clk);
    check("midrst_matrix", result_matrix, '0);
    check("midrst_flags", MW'({result_valid, busy, protocol_err, overrun_err}), '0);
    rst = 1'b0;
    idle(2);
    random_elems();
    push_expected();
    junk_beat();
    send_data(0, R-1);
    idle(1);
    wait_valid(10);
    accept(0);
    idle(3);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drained actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
